cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 LINE_WIDTH, 128, cache line width in bits; only 128 is supported.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 mem_address  in  16  CPU byte address: tag[15:7], index[6:4], offset[3:0].
REQ-005 mem_read  in  1  CPU read request, held high until mem_resp.
REQ-006 mem_write  in  1  CPU write request, held high until mem_resp.
REQ-007 mem_byte_enable  in  2  write byte lanes: bit0 = low byte, bit1 = high byte.
REQ-008 mem_wdata  in  16  CPU write word.
REQ-009 mem_rdata  out  16  CPU read word.
REQ-010 mem_resp  out  1  one-cycle completion pulse.
REQ-011 pmem_address  out  16  line address; bits [3:0] are always 0.
REQ-012 pmem_read / pmem_write  out  1 each  memory requests, held high until pmem_resp.
REQ-013 pmem_wdata  out  128  writeback line.
REQ-014 pmem_rdata  in  128  fill line.
REQ-015 pmem_resp  in  1  memory completion pulse.
REQ-016 arr_index  out  3 (cache_index)  set index driven to all storage arrays.
REQ-017 arr_write  out  1  write strobe shared by the data array and the meta array.
REQ-018 arr_datain / arr_dataout  out / in  128 each  data array write and read line.
REQ-019 arr_metain / arr_metaout  out / in  11 each  meta array contents {valid, dirty, tag[8:0]}; arrays read combinationally and write on the clock edge.
REQ-020 hit_count / miss_count  out  16 each  statistics counters (see Configuration).

Function
REQ-021 The block SHALL implement a direct-mapped, write-back, write-allocate cache with 8 sets.
REQ-022 FSM states SHALL be IDLE, CHECK, WRITEBACK and FILL.
REQ-023 IDLE transitions:
- mem_read or mem_write high: go to CHECK.
- Otherwise: stay in IDLE.
- All request outputs are low.
REQ-024 CHECK SHALL compute hit as valid AND (tag equal to mem_address[15:7]).
REQ-025 CHECK read hit:
- mem_rdata = word mem_address[3:1] of arr_dataout.
- Assert mem_resp, go to IDLE.
REQ-026 CHECK write hit:
- arr_write = 1 with arr_datain = line with the enabled bytes of word mem_address[3:1] replaced by mem_wdata.
- Meta = {1, 1, tag}.
- Assert mem_resp, go to IDLE.
REQ-027 CHECK miss: go to WRITEBACK if valid and dirty, otherwise go to FILL.
REQ-028 WRITEBACK:
- pmem_write = 1, pmem_address = {stored tag, index, 4'b0}, pmem_wdata = arr_dataout.
- On pmem_resp, go to FILL.
REQ-029 FILL:
- pmem_read = 1, pmem_address = {request tag, index, 4'b0}.
- On pmem_resp, arr_write = 1 with pmem_rdata and meta {1, 0, tag}, then go to CHECK.
REQ-030 Read-hit latency SHALL be 2 cycles from request assertion; mem_resp is asserted in the CHECK cycle.
REQ-031 When mem_read and mem_write are both high, the request SHALL be treated as a write.
REQ-032 A write with mem_byte_enable = 2'b00 SHALL leave data unchanged but still set dirty and return mem_resp.
REQ-033 arr_index SHALL always equal mem_address[6:4].
REQ-034 arr_write SHALL never be asserted outside CHECK or FILL.

Reset
REQ-035 Asserting reset_n low SHALL force the state to IDLE within the same cycle and drive every output to 0.
REQ-036 Reset SHALL apply to: mem_resp, pmem_read, pmem_write, arr_write, mem_rdata, pmem_address, pmem_wdata, arr_datain, arr_metain and both counters.
REQ-037 A reset during WRITEBACK or FILL SHALL abandon the transaction without writing the arrays; array contents are retained.

Configuration
REQ-038 With CACHE_STATS_EN defined:
- hit_count increments on every CHECK hit.
- miss_count increments on every CHECK-to-miss transition.
- Both counters saturate at 16'hFFFF.
REQ-039 Without CACHE_STATS_EN, hit_count and miss_count SHALL be tied to 0 and no counter flops SHALL be built.

Structure
REQ-040 The lc3b_types package SHALL hold:
- cache_index (3 bits), cache_tag (9 bits), cache_offset (4 bits), cache_line (128 bits).
- A packed cache_meta struct {valid, dirty, tag}.
REQ-041 The byte-merge logic SHALL be a separate combinational sub-module, line_word_merge (line, offset, byte_enable, word -> line).

Verification
REQ-042 Cold read of 16'h0A32:
- Response: CHECK miss, then FILL with pmem_address 16'h0A30.
- Then CHECK hit returning pmem_rdata word 1; miss_count = 1.
REQ-043 Write of 16'hBEEF to 16'h0A34 with enable 2'b01, then a read of the same address:
- Response: low byte becomes EF, high byte keeps the original value.
- dirty = 1; hit_count = 2.
REQ-044 Read of 16'h1A30 (same index 3, different tag) after REQ-043:
- Response: WRITEBACK to 16'h0A30 with the merged line.
- Then FILL from 16'h1A30.
REQ-045 Reset asserted while pmem_read is high in FILL:
- Response: all outputs go to 0 immediately, and the state is IDLE after release.
- The following read of 16'h1A30 misses again.
REQ-046 Hold pmem_resp low for 50 cycles during WRITEBACK:
- Response: pmem_write stays high with pmem_address stable.
- arr_write stays 0 and mem_resp stays 0.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared types for the direct-mapped cache controller: address fields, line, meta and FSM states.
package lc3b_types;

    localparam int CACHE_LINE_BITS = 128;

    typedef logic [2:0]   cache_index;
    typedef logic [8:0]   cache_tag;
    typedef logic [3:0]   cache_offset;
    typedef logic [127:0] cache_line;

    typedef struct packed {
        logic     valid;
        logic     dirty;
        cache_tag tag;
    } cache_meta;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITEBACK,
        S_FILL
    } cache_state;

    function automatic logic [15:0] word_of(input cache_line line, input logic [2:0] sel);
        return line[{sel, 4'b0000} +: 16];
    endfunction

    function automatic logic [15:0] line_addr(input cache_tag tag, input cache_index index);
        return {tag, index, 4'b0000};
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// CPU-side and physical-memory-side buses of the cache controller.
// slave: the controller's view; master: the CPU plus backing memory driving the other end.
interface cache_control_if;
    import lc3b_types::*;

    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    cache_line   pmem_wdata;
    cache_line   pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );

endinterface

// File: rtl/cache_control_merge.sv
// Replaces the enabled bytes of one 16-bit word of a cache line with a CPU write word.
module line_word_merge
    import lc3b_types::*;
(
    input  cache_line   line,
    input  cache_offset offset,
    input  logic [1:0]  byte_enable,
    input  logic [15:0] word,
    output cache_line   merged
);

    // Lines are word addressed; the byte offset LSB has no effect on a 16-bit store.
    logic unused_offset_lsb;
    assign unused_offset_lsb = offset[0];

    always_comb begin
        merged = line;
        if (byte_enable[0]) merged[{offset[3:1], 4'b0000} +: 8] = word[7:0];
        if (byte_enable[1]) merged[{offset[3:1], 4'b1000} +: 8] = word[15:8];
    end

endmodule

// File: rtl/cache_control.sv
// Direct-mapped, write-back, write-allocate cache controller with 8 sets of 128-bit lines.
// Optional hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
//
// state       | meaning
// S_IDLE      | waiting for mem_read or mem_write
// S_CHECK     | tag compare; hit completes the access, miss picks writeback or fill
// S_WRITEBACK | dirty victim line being written to physical memory
// S_FILL      | requested line being read from physical memory
module cache_control
    import lc3b_types::*;
#(
    parameter int LINE_WIDTH = CACHE_LINE_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cache_control_if.slave        bus,
    output cache_index            arr_index,
    output logic                  arr_write,
    output logic [LINE_WIDTH-1:0] arr_datain,
    input  logic [LINE_WIDTH-1:0] arr_dataout,
    output cache_meta             arr_metain,
    input  cache_meta             arr_metaout,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    cache_state state;
    cache_tag   req_tag;
    cache_index req_index;
    logic [2:0] word_sel;
    logic       req_valid;
    logic       hit;
    logic       victim_dirty;
    cache_line  merged;

    assign req_tag      = bus.mem_address[15:7];
    assign req_index    = bus.mem_address[6:4];
    assign word_sel     = bus.mem_address[3:1];
    assign req_valid    = bus.mem_read | bus.mem_write;
    assign hit          = arr_metaout.valid && (arr_metaout.tag == req_tag);
    assign victim_dirty = arr_metaout.valid && arr_metaout.dirty;
    assign arr_index    = req_index;

    line_word_merge u_merge (
        .line        (arr_dataout),
        .offset      (bus.mem_address[3:0]),
        .byte_enable (bus.mem_byte_enable),
        .word        (bus.mem_wdata),
        .merged      (merged)
    );

    // Hit completion and fill install depend on the same-cycle array read,
    // so they are decoded from the registered state rather than held in flops.
    always_comb begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        arr_write     = 1'b0;
        arr_datain    = '0;
        arr_metain    = '0;
        case (state)
            S_CHECK: begin
                if (req_valid && hit) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_write) begin
                        arr_write  = 1'b1;
                        arr_datain = merged;
                        arr_metain = {1'b1, 1'b1, req_tag};
                    end else begin
                        bus.mem_rdata = word_of(arr_dataout, word_sel);
                    end
                end
            end
            S_FILL: begin
                if (bus.pmem_resp) begin
                    arr_write  = 1'b1;
                    arr_datain = bus.pmem_rdata;
                    arr_metain = {1'b1, 1'b0, req_tag};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            bus.pmem_read    <= 1'b0;
            bus.pmem_write   <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!req_valid || hit) begin
                        state <= S_IDLE;
                    end else if (victim_dirty) begin
                        state            <= S_WRITEBACK;
                        bus.pmem_write   <= 1'b1;
                        bus.pmem_address <= line_addr(arr_metaout.tag, req_index);
                        bus.pmem_wdata   <= arr_dataout;
                    end else begin
                        state            <= S_FILL;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= line_addr(req_tag, req_index);
                    end
                end
                S_WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        state            <= S_FILL;
                        bus.pmem_write   <= 1'b0;
                        bus.pmem_read    <= 1'b1;
                        bus.pmem_address <= line_addr(req_tag, req_index);
                        bus.pmem_wdata   <= '0;
                    end
                end
                S_FILL: begin
                    if (bus.pmem_resp) begin
                        state            <= S_CHECK;
                        bus.pmem_read    <= 1'b0;
                        bus.pmem_address <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // The re-check after a fill completes a miss already counted, so it is not a hit.
    logic        refill;
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refill <= 1'b0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (state == S_CHECK && req_valid) begin
                if (hit) begin
                    refill <= 1'b0;
                    if (!refill && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
                end else if (miss_q != 16'hFFFF) begin
                    miss_q <= miss_q + 16'd1;
                end
            end else if (state == S_FILL && bus.pmem_resp) begin
                refill <= 1'b1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control with behavioural data/meta arrays and a physical memory model.
module tb_cache_control;
    import lc3b_types::*;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    cache_index arr_index;
    logic       arr_write;
    cache_line  arr_datain;
    cache_line  arr_dataout;
    cache_meta  arr_metain;
    cache_meta  arr_metaout;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_control_if bus();

    cache_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .arr_index   (arr_index),
        .arr_write   (arr_write),
        .arr_datain  (arr_datain),
        .arr_dataout (arr_dataout),
        .arr_metain  (arr_metain),
        .arr_metaout (arr_metaout),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    cache_line data_arr [8];
    cache_meta meta_arr [8];

    assign arr_dataout = data_arr[arr_index];
    assign arr_metaout = meta_arr[arr_index];

    always @(posedge clk) begin
        if (arr_write) begin
            data_arr[arr_index] <= arr_datain;
            meta_arr[arr_index] <= arr_metain;
        end
    end

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    // Word w of the line at address a reads as the line address with w in the low bits.
    function automatic cache_line fill_line(input logic [15:0] a);
        cache_line l;
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = {a[15:4], 1'b0, 3'(w)};
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no DUT event, required it within the cycle bound", name);
    endtask

    // Physical memory: answers after a programmable number of cycles.
    int          wb_lat = 2;
    int          fill_lat = 2;
    int          wait_cnt = 0;
    int          wb_count = 0;
    int          fill_count = 0;
    logic [15:0] wb_addr = '0;
    logic [15:0] fill_addr = '0;
    cache_line   wb_data = '0;

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_write === 1'b1 || bus.pmem_read === 1'b1) begin
                wait_cnt++;
                if (wait_cnt >= (bus.pmem_write ? wb_lat : fill_lat)) begin
                    if (bus.pmem_write) begin
                        wb_count++;
                        wb_addr = bus.pmem_address;
                        wb_data = bus.pmem_wdata;
                    end else begin
                        fill_count++;
                        fill_addr      = bus.pmem_address;
                        bus.pmem_rdata = fill_line(bus.pmem_address);
                    end
                    bus.pmem_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.pmem_resp = 1'b0;
                    wait_cnt      = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every mem_resp consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.mem_resp === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got mem_resp=1 required no response");
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) check("rdata", 128'(bus.mem_rdata), 128'(e.data));
                end
            end
        end
    end

    task automatic start_req(input logic [15:0] addr, input logic rd, input logic wr,
                             input logic [1:0] be, input logic [15:0] wdata, input logic [15:0] exp);
        exp_t e;
        e.is_read = rd && !wr;
        e.data    = exp;
        sb_q.push_back(e);
        bus.mem_address     = addr;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wdata;
    endtask

    task automatic wait_resp(input string name, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_resp === 1'b1) got = 1'b1;
        end
        if (!got) begin
            timeout_fail(name);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic req(input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [1:0] be, input logic [15:0] wdata, input logic [15:0] exp,
                       output int lat);
        start_req(addr, rd, wr, be, wdata, exp);
        wait_resp($sformatf("resp_%04h", addr), lat);
    endtask

    task automatic rst_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write, arr_write}), 128'(0));
        check({tag, "_addr_cnt"}, 128'({bus.pmem_address, bus.mem_rdata, hit_count, miss_count}), 128'(0));
        check({tag, "_pmem_wdata"}, bus.pmem_wdata, 128'(0));
        check({tag, "_arr_datain"}, arr_datain, 128'(0));
        check({tag, "_arr_metain"}, 128'(arr_metain), 128'(0));
    endtask

    task automatic wait_pmem(input bit want_write, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((want_write ? bus.pmem_write : bus.pmem_read) === 1'b1) got = 1'b1;
        end
        if (!got) timeout_fail(name);
    endtask

    initial begin
        int          lat;
        logic        ok;
        logic [15:0] hold_addr;
        cache_line   exp_wb;

        for (int i = 0; i < 8; i++) begin
            data_arr[i] = '0;
            meta_arr[i] = '0;
        end
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        reset_n             = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_outputs("por");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_address = 16'h0A32;
        #1;
        check("arr_index", 128'(arr_index), 128'(3'd3));

        // Cold read: miss, fill of line 0A30, word 1 returned
        req(16'h0A32, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0A31, lat);
        check("cold_fill_addr", 128'(fill_addr), 128'(16'h0A30));
        check("cold_fill_count", 128'(fill_count), 128'(1));
        check("cold_wb_count", 128'(wb_count), 128'(0));
        check("miss_count_cold", 128'(miss_count), 128'(STATS ? 16'd1 : 16'd0));
        check("hit_count_cold", 128'(hit_count), 128'(16'd0));

        // Low-byte write hit then read back
        req(16'h0A34, 1'b0, 1'b1, 2'b01, 16'hBEEF, 16'h0000, lat);
        req(16'h0A34, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0AEF, lat);
        check("read_hit_latency", 128'(lat), 128'(2));
        check("dirty_after_write", 128'(meta_arr[3].dirty), 128'(1));
        check("hit_count_after_write", 128'(hit_count), 128'(STATS ? 16'd2 : 16'd0));
        check("no_fill_on_hit", 128'(fill_count), 128'(1));

        // Conflict miss on set 3: writeback of merged line, then fill held off and reset
        exp_wb          = fill_line(16'h0A30);
        exp_wb[47:32]   = 16'h0AEF;
        wb_lat          = 3;
        fill_lat        = 100000;
        bus.mem_address = 16'h1A30;
        bus.mem_read    = 1'b1;
        wait_pmem(1'b0, "fill_start");
        check("wb_addr", 128'(wb_addr), 128'(16'h0A30));
        check("wb_data", wb_data, exp_wb);
        check("fill_req_addr", 128'(bus.pmem_address), 128'(16'h1A30));
        reset_n = 1'b0;
        #1;
        rst_outputs("mid_fill");
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 128'({bus.pmem_read, bus.pmem_write, bus.mem_resp}), 128'(0));
        check("meta_retained", 128'(meta_arr[3]), 128'({1'b1, 1'b1, 9'h014}));

        // Same read misses again; writeback stalled 50 cycles by memory
        wb_lat   = 60;
        fill_lat = 2;
        start_req(16'h1A30, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h1A30);
        wait_pmem(1'b1, "wb_start");
        hold_addr = bus.pmem_address;
        ok        = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!(bus.pmem_write === 1'b1 && bus.pmem_address === hold_addr &&
                  arr_write === 1'b0 && bus.mem_resp === 1'b0)) ok = 1'b0;
        end
        check("wb_hold_addr", 128'(hold_addr), 128'(16'h0A30));
        check("wb_hold_50", 128'(ok), 128'(1));
        wait_resp("resp_rewb", lat);
        check("rewb_count", 128'(wb_count), 128'(2));
        check("refill_addr", 128'(fill_addr), 128'(16'h1A30));
        check("miss_count_refill", 128'(miss_count), 128'(STATS ? 16'd1 : 16'd0));
        check("hit_count_refill", 128'(hit_count), 128'(16'd0));

        // Read+write together acts as a write; other words and sets
        req(16'h1A36, 1'b1, 1'b1, 2'b11, 16'h1234, 16'h0000, lat);
        req(16'h1A36, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h1234, lat);
        req(16'h1A3E, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h1A37, lat);
        req(16'h0050, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0050, lat);
        check("clean_after_fill", 128'(meta_arr[5].dirty), 128'(0));
        req(16'h0052, 1'b0, 1'b1, 2'b00, 16'hFFFF, 16'h0000, lat);
        check("dirty_be00", 128'(meta_arr[5].dirty), 128'(1));
        req(16'h0052, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0051, lat);
        req(16'h005C, 1'b0, 1'b1, 2'b10, 16'hC3A5, 16'h0000, lat);
        req(16'h005C, 1'b1, 1'b0, 2'b00, 16'h0000, 16'hC356, lat);

        repeat (3) @(posedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
